// File: rtl/heartbeat_monitor_pkg.sv
// Shared types and defaults for the CPU heartbeat watchdog.
// The default period limits assume a 50 MHz system oscillator.
package heartbeat_monitor_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_OK      = 2'd1,
        ST_FAULT   = 2'd2
    } hb_state_t;

    localparam int unsigned OSC_KHZ        = 50_000;
    localparam int          DEF_SYNC       = 2;
    localparam int          DEF_FILT       = 4;
    localparam int          DEF_CNT_W      = 24;
    localparam int          DEF_GOOD_N     = 4;
    // 100 us shortest and 8 ms longest heartbeat period
    localparam logic [23:0] DEF_MIN_PERIOD = 24'(OSC_KHZ / 10);
    localparam logic [23:0] DEF_MAX_PERIOD = 24'(OSC_KHZ * 8);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hb_glitch_filter.sv
// Synchroniser plus run-length glitch filter for the raw heartbeat pin.
// hb_event is a registered one-cycle pulse on each rising edge of the filtered level.
module hb_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT        = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm,
    output logic level,
    output logic hb_event
);

    localparam int FC_W = $clog2(FILT + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FC_W-1:0]        run_cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // run_cnt counts consecutive synced samples that disagree with level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            run_cnt  <= '0;
            level    <= 1'b0;
            hb_event <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm};
            hb_event <= 1'b0;
            if (synced != level) begin
                if (run_cnt == FC_W'(FILT - 1)) begin
                    level    <= synced;
                    run_cnt  <= '0;
                    hb_event <= synced;
                end else begin
                    run_cnt <= run_cnt + FC_W'(1);
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/heartbeat_monitor.sv
// Per-CPU heartbeat watchdog: checks each rise-to-rise period against a window
// and drives a registered health level for the A/B switch logic.
module heartbeat_monitor
    import heartbeat_monitor_pkg::*;
#(
    parameter int               SYNC_STAGES = DEF_SYNC,
    parameter int               FILT        = DEF_FILT,
    parameter int               CNT_W       = DEF_CNT_W,
    parameter logic [CNT_W-1:0] MIN_PERIOD  = CNT_W'(DEF_MIN_PERIOD),
    parameter logic [CNT_W-1:0] MAX_PERIOD  = CNT_W'(DEF_MAX_PERIOD),
    parameter int               GOOD_N      = DEF_GOOD_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm,
    input  logic             clr_cnt,
    output logic             io,
    output logic             fault_pulse,
    output logic [7:0]       fault_cnt,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output hb_state_t        dbg_state
);

    localparam int GC_W = $clog2(GOOD_N + 1);

    hb_state_t        state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W:0]   cnt_p1;
    logic [GC_W-1:0]  good_cnt;
    logic             filt_level;
    logic             hb_event;
    logic             good;
    logic             bad;
    logic             timeout;
    logic             enter_fault;

    hb_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT        (FILT)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm      (pwm),
        .level    (filt_level),
        .hb_event (hb_event)
    );

    // cnt_p1 is the length of the current period if a heartbeat lands this cycle
    assign cnt_p1  = {1'b0, counter} + {{CNT_W{1'b0}}, 1'b1};
    assign good    = hb_event && (cnt_p1 >= {1'b0, MIN_PERIOD}) && (cnt_p1 <= {1'b0, MAX_PERIOD});
    assign bad     = hb_event && !good;
    assign timeout = !hb_event && (cnt_p1 == {1'b0, MAX_PERIOD});

    always_comb begin
        enter_fault = 1'b0;
        case (state)
            ST_ACQUIRE: enter_fault = timeout;
            ST_OK:      enter_fault = bad || timeout;
            default:    enter_fault = 1'b0;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ACQUIRE;
            io          <= 1'b1;
            fault_pulse <= 1'b0;
            fault_cnt   <= 8'd0;
            period      <= '0;
            period_vld  <= 1'b0;
            counter     <= '0;
            good_cnt    <= '0;
        end else begin
            fault_pulse <= enter_fault;
            period_vld  <= 1'b0;

            if (hb_event || timeout) begin
                counter <= '0;
            end else if (counter != '1) begin
                counter <= counter + CNT_W'(1);
            end

            // the acquiring heartbeat has no valid start point, so it is not reported
            if (hb_event && state != ST_ACQUIRE) begin
                period     <= cnt_p1[CNT_W-1:0];
                period_vld <= 1'b1;
            end

            if (enter_fault) begin
                fault_cnt <= clr_cnt ? 8'd1 : sat_inc8(fault_cnt);
            end else if (clr_cnt) begin
                fault_cnt <= 8'd0;
            end

            case (state)
                ST_ACQUIRE: begin
                    if (hb_event) begin
                        state <= ST_OK;
                    end else if (timeout) begin
                        state <= ST_FAULT;
                        io    <= 1'b0;
                    end
                end
                ST_OK: begin
                    if (bad || timeout) begin
                        state <= ST_FAULT;
                        io    <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    if (good) begin
                        if (good_cnt == GC_W'(GOOD_N - 1)) begin
                            state    <= ST_OK;
                            io       <= 1'b1;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + GC_W'(1);
                        end
                    end else if (bad || timeout) begin
                        good_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_ACQUIRE;
                    io       <= 1'b1;
                    good_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed plus randomized heartbeat waveforms checked cycle by cycle against
// a timestamp-based reference model of the watchdog rules.
module tb_heartbeat_monitor;
    import heartbeat_monitor_pkg::*;

    localparam int SYNC  = 2;
    localparam int FILT  = 2;
    localparam int CNT_W = 24;
    localparam int MINP  = 8;
    localparam int MAXP  = 32;
    localparam int GOODN = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pwm = 1'b0;
    logic             clr_cnt = 1'b0;
    logic             io;
    logic             fault_pulse;
    logic [7:0]       fault_cnt;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    hb_state_t        dbg_state;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    heartbeat_monitor #(
        .SYNC_STAGES (SYNC),
        .FILT        (FILT),
        .CNT_W       (CNT_W),
        .MIN_PERIOD  (24'(MINP)),
        .MAX_PERIOD  (24'(MAXP)),
        .GOOD_N      (GOODN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm         (pwm),
        .clr_cnt     (clr_cnt),
        .io          (io),
        .fault_pulse (fault_pulse),
        .fault_cnt   (fault_cnt),
        .period      (period),
        .period_vld  (period_vld),
        .dbg_state   (dbg_state)
    );

    // reference model: time since last period restart, plus a pin history for the filter
    int        cyc;
    int        clr_edge;
    bit        pin_q[$];
    bit        m_lvl;
    bit        m_ev;
    hb_state_t m_st;
    int        m_good;
    bit        m_io;
    bit        m_pulse;
    bit        m_vld;
    int        m_fcnt;
    int        m_period;

    function automatic void model_reset();
        cyc      = 0;
        clr_edge = 0;
        pin_q.delete();
        for (int i = 0; i < SYNC + FILT; i++) pin_q.push_back(1'b0);
        m_lvl    = 1'b0;
        m_ev     = 1'b0;
        m_st     = ST_ACQUIRE;
        m_good   = 0;
        m_io     = 1'b1;
        m_pulse  = 1'b0;
        m_vld    = 1'b0;
        m_fcnt   = 0;
        m_period = 0;
    endfunction

    function automatic void model_step();
        int p;
        bit ev, good, bad, tmo, enter, all_diff;
        cyc++;
        p     = cyc - clr_edge;
        ev    = m_ev;
        good  = ev && p >= MINP && p <= MAXP;
        bad   = ev && !good;
        tmo   = !ev && p == MAXP;
        enter = 1'b0;
        m_pulse = 1'b0;
        m_vld   = 1'b0;
        if (ev || tmo) clr_edge = cyc;
        if (ev && m_st != ST_ACQUIRE) begin
            m_period = p;
            m_vld    = 1'b1;
        end
        case (m_st)
            ST_ACQUIRE: if (ev) m_st = ST_OK; else if (tmo) enter = 1'b1;
            ST_OK:      if (bad || tmo) enter = 1'b1;
            default: begin
                if (good) begin
                    m_good++;
                    if (m_good == GOODN) begin
                        m_good = 0;
                        m_st   = ST_OK;
                        m_io   = 1'b1;
                    end
                end else if (bad || tmo) begin
                    m_good = 0;
                end
            end
        endcase
        if (enter) begin
            m_st    = ST_FAULT;
            m_io    = 1'b0;
            m_pulse = 1'b1;
            m_fcnt  = clr_cnt ? 1 : ((m_fcnt == 255) ? 255 : m_fcnt + 1);
        end else if (clr_cnt) begin
            m_fcnt = 0;
        end
        // filtered level flips once the last FILT synced samples all disagree with it
        pin_q.push_back(pwm);
        void'(pin_q.pop_front());
        all_diff = 1'b1;
        for (int k = SYNC; k < SYNC + FILT; k++)
            if (pin_q[pin_q.size() - 1 - k] == m_lvl) all_diff = 1'b0;
        m_ev = 1'b0;
        if (all_diff) begin
            m_lvl = !m_lvl;
            m_ev  = m_lvl;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic compare_all();
        check("io",          32'(io),          32'(m_io));
        check("fault_pulse", 32'(fault_pulse), 32'(m_pulse));
        check("fault_cnt",   32'(fault_cnt),   32'(m_fcnt));
        check("period",      32'(period),      32'(m_period));
        check("period_vld",  32'(period_vld),  32'(m_vld));
        check("state",       32'(dbg_state),   32'(m_st));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        compare_all();
    endtask

    task automatic drive_period(input int per);
        int hi;
        hi = $urandom_range(per - FILT, FILT);
        for (int i = 0; i < per; i++) begin
            pwm = (i < hi);
            tick();
        end
    endtask

    // 20-cycle wave with a 1-cycle low dip in the high phase and a 1-cycle spike in the low phase
    task automatic glitch_period();
        int spike;
        spike = $urandom_range(17, 10);
        for (int i = 0; i < 20; i++) begin
            pwm = ((i < 8) && (i != 4)) || (i == spike);
            tick();
        end
    endtask

    task automatic hold(input bit lvl, input int n);
        pwm = lvl;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bit found;

        // reset
        model_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;

        // acquire on a 20-cycle square wave
        for (int i = 0; i < 6; i++) drive_period(20);
        check("t1_period", 32'(period), 32'd20);
        check("t1_io", 32'(io), 32'd1);
        check("t1_fault_cnt", 32'(fault_cnt), 32'd0);

        // stuck low: one timeout fault, no repeat pulses
        hold(1'b0, 80);
        check("t2_io", 32'(io), 32'd0);
        check("t2_fault_cnt", 32'(fault_cnt), 32'd1);

        // recover with good periods
        for (int i = 0; i < 5; i++) drive_period(20);
        check("t3_io", 32'(io), 32'd1);

        // one short period from OK
        drive_period(5);
        drive_period(20);
        check("t4_period", 32'(period), 32'd5);
        check("t4_io", 32'(io), 32'd0);
        check("t4_fault_cnt", 32'(fault_cnt), 32'd2);

        // two good periods then a short one keeps FAULT
        drive_period(20);
        drive_period(5);
        drive_period(20);
        check("t3b_io", 32'(io), 32'd0);
        for (int i = 0; i < 4; i++) drive_period(20);
        check("t3b_recover_io", 32'(io), 32'd1);

        // glitches must not create heartbeats
        for (int i = 0; i < 6; i++) glitch_period();
        check("t5_period", 32'(period), 32'd20);
        check("t5_io", 32'(io), 32'd1);

        // stuck high also times out
        hold(1'b1, 70);
        hold(1'b0, 4);
        for (int i = 0; i < 5; i++) drive_period(20);

        // randomized periods spanning short, good and timeout lengths
        for (int i = 0; i < 150; i++) drive_period($urandom_range(45, 2 * FILT));
        for (int i = 0; i < 5; i++) drive_period($urandom_range(MAXP - 2, MINP + 2));

        // saturate fault_cnt
        for (int f = 0; f < 260; f++) begin
            drive_period(5);
            for (int j = 0; j < 4; j++) drive_period($urandom_range(12, MINP));
        end
        check("t6_saturate", 32'(fault_cnt), 32'd255);

        // clr_cnt in the same cycle as a timeout fault entry
        pwm   = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (!m_ev && m_st == ST_OK && (cyc + 1 - clr_edge) == MAXP) found = 1'b1;
            else tick();
        end
        vectors++;
        if (!found) begin
            errors++;
            $display("FAIL t6_clr_sync: observed no fault entry within 100 cycles, expected one");
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("t6_clr_coincide", 32'(fault_cnt), 32'd1);
        check("t6_clr_pulse", 32'(fault_pulse), 32'd1);
        hold(1'b0, 3);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("t6_clr_alone", 32'(fault_cnt), 32'd0);

        // asynchronous reset mid-period
        for (int i = 0; i < 5; i++) drive_period(20);
        hold(1'b1, 5);
        rst_n = 1'b0;
        pwm   = 1'b0;
        #1;
        model_reset();
        compare_all();
        for (int i = 0; i < 2; i++) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive_period(20);
        check("t6_after_reset_io", 32'(io), 32'd1);
        check("t6_after_reset_period", 32'(period), 32'd20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "time limit reached");
    end

endmodule
